// File: rtl/psram_scheduler_if.sv
// Command/data bus between the PSRAM scheduler (master) and the quad-SPI PSRAM driver (slave).
interface psram_scheduler_if;
    localparam int unsigned ADDR_W = 23;
    localparam int unsigned DATA_W = 16;

    logic [ADDR_W-1:0] psram_address;
    logic [1:0]        psram_read_write;
    logic              psram_quad_start;
    logic              psram_burst_mode;
    logic              endcommand;
    logic              qpi_on;
    logic              fifo_rd;
    logic [DATA_W-1:0] psram_data_out;

    modport master (
        output psram_address, psram_read_write, psram_quad_start, psram_burst_mode,
        input  endcommand, qpi_on, fifo_rd, psram_data_out
    );

    modport slave (
        input  psram_address, psram_read_write, psram_quad_start, psram_burst_mode,
        output endcommand, qpi_on, fifo_rd, psram_data_out
    );
endinterface

// File: rtl/psram_scheduler.sv
// Arbitrates the quad-SPI PSRAM driver between the acquisition write path and host single-word
// reads; owns the circular write pointer, the read starvation guard and the command watchdog.
module psram_scheduler #(
    parameter int unsigned FIFO_AW       = 10,
    parameter int unsigned WR_THRESHOLD  = 4,
    parameter int unsigned MAX_WR_GRANTS = 8,
    parameter logic [22:0] MEM_TOP       = 23'h7FFFFE,
    parameter bit          WRAP_EN       = 1'b1,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic               mem_clk,
    input  logic               rst,
    psram_scheduler_if.master  bus,
    input  logic               acq_en,
    input  logic               fifo_empty,
    input  logic [FIFO_AW-1:0] fifo_count,
    input  logic               rd_req,
    input  logic [22:0]        rd_addr,
    output logic               rd_ack,
    output logic [15:0]        rd_data,
    output logic [22:0]        wr_ptr,
    output logic               wrapped,
    output logic               mem_full,
    output logic               timeout_err,
    output logic               busy
);
    localparam int unsigned GC_W = $clog2(MAX_WR_GRANTS + 1);
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WR_ISSUE,
        ST_WR_WAIT,
        ST_RD_ISSUE,
        ST_RD_WAIT
    } state_t;

    state_t          state;
    logic [GC_W-1:0] grant_cnt;
    logic [WD_W-1:0] wd_cnt;

    logic write_ok_c;
    logic rd_pend_c;
    logic wr_pref_c;
    logic wd_expire_c;

    // While rd_ack is high the request level still belongs to the read just served.
    assign write_ok_c  = acq_en & ~fifo_empty & ~mem_full;
    assign rd_pend_c   = rd_req & ~rd_ack;
    assign wr_pref_c   = (fifo_count >= FIFO_AW'(WR_THRESHOLD)) &&
                         (grant_cnt < GC_W'(MAX_WR_GRANTS));
    assign wd_expire_c = (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state                <= ST_INIT;
            grant_cnt            <= '0;
            wd_cnt               <= '0;
            bus.psram_address    <= '0;
            bus.psram_read_write <= 2'd0;
            bus.psram_quad_start <= 1'b0;
            bus.psram_burst_mode <= 1'b0;
            rd_ack               <= 1'b0;
            rd_data              <= '0;
            wr_ptr               <= '0;
            wrapped              <= 1'b0;
            mem_full             <= 1'b0;
            timeout_err          <= 1'b0;
            busy                 <= 1'b0;
        end else begin
            bus.psram_quad_start <= 1'b0;
            rd_ack               <= 1'b0;

            if (!rd_req) begin
                grant_cnt <= '0;
            end

            // Every pop of a write burst, including the one in the issue cycle, moves the pointer.
            if (bus.fifo_rd && (state == ST_WR_ISSUE || state == ST_WR_WAIT)) begin
                if (wr_ptr == MEM_TOP) begin
                    if (WRAP_EN) begin
                        wr_ptr  <= '0;
                        wrapped <= 1'b1;
                    end else begin
                        mem_full <= 1'b1;
                    end
                end else begin
                    wr_ptr <= wr_ptr + 23'd2;
                end
            end

            case (state)
                ST_INIT: begin
                    if (bus.qpi_on) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (!bus.qpi_on) begin
                        state <= ST_INIT;
                    end else if (write_ok_c && (!rd_pend_c || wr_pref_c)) begin
                        state                <= ST_WR_ISSUE;
                        bus.psram_address    <= wr_ptr;
                        bus.psram_read_write <= 2'd1;
                        bus.psram_burst_mode <= 1'b1;
                        bus.psram_quad_start <= 1'b1;
                        busy                 <= 1'b1;
                        grant_cnt            <= rd_pend_c ? grant_cnt + GC_W'(1) : '0;
                    end else if (rd_pend_c) begin
                        state                <= ST_RD_ISSUE;
                        bus.psram_address    <= rd_addr;
                        bus.psram_read_write <= 2'd2;
                        bus.psram_burst_mode <= 1'b0;
                        bus.psram_quad_start <= 1'b1;
                        busy                 <= 1'b1;
                        grant_cnt            <= '0;
                    end
                end
                ST_WR_ISSUE: begin
                    state  <= ST_WR_WAIT;
                    wd_cnt <= '0;
                end
                ST_RD_ISSUE: begin
                    state  <= ST_RD_WAIT;
                    wd_cnt <= '0;
                end
                ST_WR_WAIT, ST_RD_WAIT: begin
                    if (bus.endcommand) begin
                        if (state == ST_RD_WAIT) begin
                            rd_data <= bus.psram_data_out;
                            rd_ack  <= 1'b1;
                        end
                        state                <= ST_IDLE;
                        bus.psram_read_write <= 2'd0;
                        bus.psram_burst_mode <= 1'b0;
                        busy                 <= 1'b0;
                    end else if (wd_expire_c) begin
                        // Abort without ack; a pending read is simply re-arbitrated from IDLE.
                        state                <= ST_IDLE;
                        timeout_err          <= 1'b1;
                        bus.psram_read_write <= 2'd0;
                        bus.psram_burst_mode <= 1'b0;
                        busy                 <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_psram_scheduler.sv
// Directed bench for psram_scheduler: arbitration, pointer wrap/full, watchdog and reset.
module tb_psram_scheduler;
    logic        mem_clk = 1'b0;
    logic        rst;
    logic        acq_en, fifo_empty, rd_req;
    logic [9:0]  fifo_count;
    logic [22:0] rd_addr;
    logic        rd_ack, wrapped, mem_full, timeout_err, busy;
    logic [15:0] rd_data;
    logic [22:0] wr_ptr;

    logic        n_acq_en, n_fifo_empty, n_rd_req;
    logic [9:0]  n_fifo_count;
    logic [22:0] n_rd_addr;
    logic        n_rd_ack, n_wrapped, n_mem_full, n_timeout_err, n_busy;
    logic [15:0] n_rd_data;
    logic [22:0] n_wr_ptr;

    int checks = 0;
    int errors = 0;

    psram_scheduler_if bus ();
    psram_scheduler_if bus2 ();

    psram_scheduler #(.MEM_TOP(23'h00003E), .WRAP_EN(1'b1)) u_dut (
        .mem_clk(mem_clk), .rst(rst), .bus(bus), .acq_en(acq_en), .fifo_empty(fifo_empty),
        .fifo_count(fifo_count), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_data(rd_data), .wr_ptr(wr_ptr), .wrapped(wrapped), .mem_full(mem_full),
        .timeout_err(timeout_err), .busy(busy)
    );

    psram_scheduler #(.MEM_TOP(23'h00000E), .WRAP_EN(1'b0)) u_nowrap (
        .mem_clk(mem_clk), .rst(rst), .bus(bus2), .acq_en(n_acq_en), .fifo_empty(n_fifo_empty),
        .fifo_count(n_fifo_count), .rd_req(n_rd_req), .rd_addr(n_rd_addr), .rd_ack(n_rd_ack),
        .rd_data(n_rd_data), .wr_ptr(n_wr_ptr), .wrapped(n_wrapped), .mem_full(n_mem_full),
        .timeout_err(n_timeout_err), .busy(n_busy)
    );

    always #5 mem_clk = ~mem_clk;

    // Bounded wait for a quad_start on the main bus; n = negedges waited, -1 on expiry.
    task automatic wait_qs(input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc && n < 0; i++) begin
            @(negedge mem_clk);
            if (bus.psram_quad_start) n = i;
        end
    endtask

    // Driver model for a write burst, entered on the quad_start (issue) cycle.
    task automatic run_burst(input int pops);
        bus.fifo_rd = 1'b1;
        repeat (pops) @(negedge mem_clk);
        bus.fifo_rd    = 1'b0;
        bus.endcommand = 1'b1;
        @(negedge mem_clk);
        bus.endcommand = 1'b0;
    endtask

    task automatic test_reset();
        int qs_seen;
        int busy_seen;
        rst = 1'b1; acq_en = 1'b0; fifo_empty = 1'b1; fifo_count = '0; rd_req = 1'b0; rd_addr = '0;
        bus.qpi_on = 1'b0; bus.endcommand = 1'b0; bus.fifo_rd = 1'b0; bus.psram_data_out = '0;
        bus2.qpi_on = 1'b0; bus2.endcommand = 1'b0; bus2.fifo_rd = 1'b0; bus2.psram_data_out = '0;
        n_acq_en = 1'b0; n_fifo_empty = 1'b1; n_fifo_count = '0; n_rd_req = 1'b0; n_rd_addr = '0;
        repeat (3) @(negedge mem_clk);
        rst = 1'b0;
        @(negedge mem_clk);
        checks++;
        if ({rd_ack, rd_data, wr_ptr, wrapped, mem_full, timeout_err, busy, bus.psram_address,
             bus.psram_read_write, bus.psram_quad_start, bus.psram_burst_mode} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%0b data=%0h ptr=%0h flags=%0b%0b%0b busy=%0b addr=%0h rw=%0d qs=%0b bm=%0b required all 0",
                     rd_ack, rd_data, wr_ptr, wrapped, mem_full, timeout_err, busy,
                     bus.psram_address, bus.psram_read_write, bus.psram_quad_start, bus.psram_burst_mode);
        end
        // Read request raised while the PSRAM is still initialising must be held off.
        rd_req = 1'b1; rd_addr = 23'h001234;
        qs_seen = 0; busy_seen = 0;
        repeat (16) begin
            @(negedge mem_clk);
            if (bus.psram_quad_start) qs_seen++;
            if (busy) busy_seen++;
        end
        checks++;
        if (qs_seen != 0 || busy_seen != 0) begin
            errors++;
            $display("FAIL init_hold: got quad_start=%0d busy=%0d cycles required 0,0", qs_seen, busy_seen);
        end
    endtask

    task automatic test_read_only();
        int n;
        bus.qpi_on = 1'b1;
        wait_qs(10, n);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL rd_issue_latency: got %0d cycles required 2", n);
        end
        checks++;
        if (bus.psram_read_write !== 2'd2 || bus.psram_address !== 23'h001234 ||
            bus.psram_burst_mode !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rd_issue: got rw=%0d addr=%0h bm=%0b busy=%0b required rw=2 addr=1234 bm=0 busy=1",
                     bus.psram_read_write, bus.psram_address, bus.psram_burst_mode, busy);
        end
        repeat (3) @(negedge mem_clk);
        bus.psram_data_out = 16'hBEEF;
        bus.endcommand = 1'b1;
        @(negedge mem_clk);
        bus.endcommand = 1'b0;
        checks++;
        if (rd_ack !== 1'b1 || rd_data !== 16'hBEEF || bus.psram_read_write !== 2'd0) begin
            errors++;
            $display("FAIL rd_done: got ack=%0b data=%0h rw=%0d required ack=1 data=beef rw=0",
                     rd_ack, rd_data, bus.psram_read_write);
        end
        rd_req = 1'b0;
        @(negedge mem_clk);
        checks++;
        if (rd_ack !== 1'b0 || busy !== 1'b0 || bus.psram_quad_start !== 1'b0) begin
            errors++;
            $display("FAIL rd_ack_pulse: got ack=%0b busy=%0b qs=%0b required 0,0,0",
                     rd_ack, busy, bus.psram_quad_start);
        end
    endtask

    task automatic test_write_only();
        int n;
        acq_en = 1'b1; fifo_count = 10'd5; fifo_empty = 1'b0;
        wait_qs(10, n);
        checks++;
        if (n < 0 || bus.psram_read_write !== 2'd1 || bus.psram_burst_mode !== 1'b1 ||
            bus.psram_address !== 23'h0) begin
            errors++;
            $display("FAIL wr_issue: got wait=%0d rw=%0d bm=%0b addr=%0h required rw=1 bm=1 addr=0",
                     n, bus.psram_read_write, bus.psram_burst_mode, bus.psram_address);
        end
        bus.fifo_rd = 1'b1;
        repeat (2) @(negedge mem_clk);
        checks++;
        if (wr_ptr !== 23'd4 || bus.psram_quad_start !== 1'b0 || bus.psram_burst_mode !== 1'b1 ||
            bus.psram_read_write !== 2'd1) begin
            errors++;
            $display("FAIL wr_mid_burst: got ptr=%0d qs=%0b bm=%0b rw=%0d required 4,0,1,1",
                     wr_ptr, bus.psram_quad_start, bus.psram_burst_mode, bus.psram_read_write);
        end
        repeat (3) @(negedge mem_clk);
        bus.fifo_rd = 1'b0; bus.endcommand = 1'b1; fifo_empty = 1'b1; fifo_count = '0;
        @(negedge mem_clk);
        bus.endcommand = 1'b0;
        checks++;
        if (wr_ptr !== 23'd10 || bus.psram_read_write !== 2'd0 || bus.psram_burst_mode !== 1'b0 ||
            busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_done: got ptr=%0d rw=%0d bm=%0b busy=%0b required 10,0,0,0",
                     wr_ptr, bus.psram_read_write, bus.psram_burst_mode, busy);
        end
        wait_qs(5, n);
        checks++;
        if (n >= 0) begin
            errors++;
            $display("FAIL wr_no_regrant: got quad_start after %0d cycles required none", n);
        end
    endtask

    task automatic test_contention();
        int n;
        int wr_grants;
        bit got_read;
        bit stop;
        wr_grants = 0; got_read = 1'b0; stop = 1'b0;
        rd_req = 1'b1; rd_addr = 23'h000100; fifo_count = 10'd20; fifo_empty = 1'b0;
        for (int k = 0; k < 12 && !stop; k++) begin
            wait_qs(10, n);
            if (n < 0) begin
                stop = 1'b1;
            end else if (bus.psram_read_write == 2'd1) begin
                wr_grants++;
                run_burst(2);
            end else begin
                got_read = 1'b1;
                stop = 1'b1;
            end
        end
        fifo_empty = 1'b1;
        checks++;
        if (wr_grants != 8 || !got_read || bus.psram_address !== 23'h000100) begin
            errors++;
            $display("FAIL contention_grants: got writes=%0d read=%0b addr=%0h required 8,1,100",
                     wr_grants, got_read, bus.psram_address);
        end
        repeat (2) @(negedge mem_clk);
        bus.psram_data_out = 16'h5A5A;
        bus.endcommand = 1'b1;
        @(negedge mem_clk);
        bus.endcommand = 1'b0;
        rd_req = 1'b0;
        checks++;
        if (rd_ack !== 1'b1 || rd_data !== 16'h5A5A || u_dut.grant_cnt !== '0) begin
            errors++;
            $display("FAIL contention_read: got ack=%0b data=%0h grant_cnt=%0d required 1,5a5a,0",
                     rd_ack, rd_data, u_dut.grant_cnt);
        end
        checks++;
        if (wr_ptr !== 23'd42) begin
            errors++;
            $display("FAIL contention_ptr: got %0d required 42", wr_ptr);
        end
    endtask

    task automatic test_wrap();
        int n;
        fifo_count = 10'd20; fifo_empty = 1'b0;
        wait_qs(10, n);
        run_burst(8);
        checks++;
        if (n < 0 || wr_ptr !== 23'h00003A || wrapped !== 1'b0) begin
            errors++;
            $display("FAIL wrap_preset: got wait=%0d ptr=%0h wrapped=%0b required ptr=3a wrapped=0",
                     n, wr_ptr, wrapped);
        end
        wait_qs(10, n);
        bus.fifo_rd = 1'b1;
        @(negedge mem_clk);
        checks++;
        if (wr_ptr !== 23'h00003C) begin
            errors++;
            $display("FAIL wrap_step1: got %0h required 3c", wr_ptr);
        end
        @(negedge mem_clk);
        checks++;
        if (wr_ptr !== 23'h00003E || wrapped !== 1'b0) begin
            errors++;
            $display("FAIL wrap_step2: got ptr=%0h wrapped=%0b required 3e,0", wr_ptr, wrapped);
        end
        @(negedge mem_clk);
        bus.fifo_rd = 1'b0; bus.endcommand = 1'b1; fifo_empty = 1'b1;
        checks++;
        if (wr_ptr !== 23'h0 || wrapped !== 1'b1) begin
            errors++;
            $display("FAIL wrap_step3: got ptr=%0h wrapped=%0b required 0,1", wr_ptr, wrapped);
        end
        @(negedge mem_clk);
        bus.endcommand = 1'b0;
    endtask

    task automatic test_no_wrap();
        int n;
        int qs_seen;
        bus2.qpi_on = 1'b1; n_acq_en = 1'b1; n_fifo_empty = 1'b0; n_fifo_count = 10'd20;
        n = -1;
        for (int i = 1; i <= 10 && n < 0; i++) begin
            @(negedge mem_clk);
            if (bus2.psram_quad_start) n = i;
        end
        bus2.fifo_rd = 1'b1;
        repeat (7) @(negedge mem_clk);
        checks++;
        if (n < 0 || n_wr_ptr !== 23'h00000E || n_mem_full !== 1'b0) begin
            errors++;
            $display("FAIL nowrap_top: got wait=%0d ptr=%0h full=%0b required ptr=e full=0",
                     n, n_wr_ptr, n_mem_full);
        end
        @(negedge mem_clk);
        bus2.fifo_rd = 1'b0; bus2.endcommand = 1'b1;
        checks++;
        if (n_wr_ptr !== 23'h00000E || n_mem_full !== 1'b1 || n_wrapped !== 1'b0) begin
            errors++;
            $display("FAIL nowrap_full: got ptr=%0h full=%0b wrapped=%0b required e,1,0",
                     n_wr_ptr, n_mem_full, n_wrapped);
        end
        @(negedge mem_clk);
        bus2.endcommand = 1'b0;
        qs_seen = 0;
        repeat (20) begin
            @(negedge mem_clk);
            if (bus2.psram_quad_start) qs_seen++;
        end
        checks++;
        if (qs_seen != 0 || n_busy !== 1'b0) begin
            errors++;
            $display("FAIL nowrap_blocked: got quad_start=%0d busy=%0b required 0,0", qs_seen, n_busy);
        end
    endtask

    task automatic test_watchdog();
        int n;
        int n_to;
        int acks;
        rd_req = 1'b1; rd_addr = 23'h0000AA; fifo_empty = 1'b1;
        wait_qs(10, n);
        checks++;
        if (n < 0 || bus.psram_read_write !== 2'd2) begin
            errors++;
            $display("FAIL wd_issue: got wait=%0d rw=%0d required read issue", n, bus.psram_read_write);
        end
        n_to = -1; acks = 0;
        for (int i = 1; i <= 400 && n_to < 0; i++) begin
            @(negedge mem_clk);
            if (rd_ack) acks++;
            if (timeout_err) n_to = i;
        end
        checks++;
        if (n_to != 256 || acks != 0 || bus.psram_read_write !== 2'd0) begin
            errors++;
            $display("FAIL wd_expire: got cycles=%0d acks=%0d rw=%0d required 256,0,0",
                     n_to, acks, bus.psram_read_write);
        end
        wait_qs(5, n);
        checks++;
        if (n != 1 || bus.psram_read_write !== 2'd2 || bus.psram_address !== 23'h0000AA) begin
            errors++;
            $display("FAIL wd_retry: got wait=%0d rw=%0d addr=%0h required 1,2,aa",
                     n, bus.psram_read_write, bus.psram_address);
        end
        repeat (2) @(negedge mem_clk);
        bus.psram_data_out = 16'hCAFE;
        bus.endcommand = 1'b1;
        @(negedge mem_clk);
        bus.endcommand = 1'b0;
        rd_req = 1'b0;
        checks++;
        if (rd_ack !== 1'b1 || rd_data !== 16'hCAFE || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL wd_retry_done: got ack=%0b data=%0h terr=%0b required 1,cafe,1",
                     rd_ack, rd_data, timeout_err);
        end
    endtask

    task automatic test_sync_reset();
        rst = 1'b1;
        @(negedge mem_clk);
        checks++;
        if (wr_ptr !== '0 || wrapped !== 1'b0 || timeout_err !== 1'b0 || rd_data !== '0 ||
            busy !== 1'b0 || n_mem_full !== 1'b0 || n_wr_ptr !== '0) begin
            errors++;
            $display("FAIL sync_reset: got ptr=%0h wrapped=%0b terr=%0b data=%0h busy=%0b nfull=%0b nptr=%0h required all 0",
                     wr_ptr, wrapped, timeout_err, rd_data, busy, n_mem_full, n_wr_ptr);
        end
        rst = 1'b0;
        @(negedge mem_clk);
    endtask

    initial begin
        test_reset();
        test_read_only();
        test_write_only();
        test_contention();
        test_wrap();
        test_no_wrap();
        test_watchdog();
        test_sync_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/psram_scheduler.md
Name: psram_scheduler

Overview:
- Sequences and arbitrates the quad-SPI PSRAM driver between two requesters: the ADC acquisition write path (FIFO drain, burst writes) and a host readback port (single-word reads).
- Sits between the acquisition FIFO / host command logic and the psram top.
- Drives psram address, read_write, quad_start and burst_mode; consumes endcommand, qpi_on, fifo_rd and data_out.
- Owns the circular write pointer, the starvation guard and the per-command watchdog.

Parameters:
- FIFO_AW, 10, width of the acquisition FIFO occupancy count.
- WR_THRESHOLD, 4, minimum FIFO occupancy that triggers a write grant when a read is pending.
- MAX_WR_GRANTS, 8, consecutive write grants allowed while a read is pending before the read is forced.
- MEM_TOP, 23'h7FFFFE, last valid word byte-address of the write region.
- WRAP_EN, 1, 1 = circular buffer; 0 = stop at MEM_TOP.
- TIMEOUT, 255, mem_clk cycles allowed from quad_start to endcommand.

Ports:
- mem_clk  in  1  system/PSRAM clock (84 MHz); all logic on posedge.
- rst  in  1  synchronous active-high reset.
- acq_en  in  1  enables write grants; clearing it stops new writes only.
- qpi_on  in  1  PSRAM initialisation done.
- endcommand  in  1  one-cycle pulse from psram marking command end.
- fifo_empty  in  1  acquisition FIFO empty.
- fifo_count  in  FIFO_AW  acquisition FIFO occupancy.
- fifo_rd  in  1  word-pop strobe issued by the psram driver.
- psram_data_out  in  16  read data from psram.
- rd_req  in  1  host read request; level, held until rd_ack.
- rd_addr  in  23  host read byte-address.
- psram_address  out  23  address presented to psram.
- psram_read_write  out  2  0 = none, 1 = write, 2 = read.
- psram_quad_start  out  1  command start pulse.
- psram_burst_mode  out  1  1 during write grants.
- rd_ack  out  1  one-cycle pulse; rd_data valid.
- rd_data  out  16  captured read word.
- wr_ptr  out  23  next write byte-address.
- wrapped  out  1  sticky; set when wr_ptr has wrapped.
- mem_full  out  1  sticky; WRAP_EN = 0 and region exhausted.
- timeout_err  out  1  sticky watchdog error.
- busy  out  1  1 in any state except INIT/IDLE.

Behaviour:
- Reset values: all outputs 0; state INIT; wr_ptr 0; grant counter 0; watchdog 0.
- Registered state machine: INIT, IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT.
- INIT: outputs idle. Moves to IDLE on the first cycle qpi_on = 1. Requests are ignored until then; rd_req stays pending and is served later.
- IDLE decision, evaluated every cycle:
  - write_ok = acq_en & !fifo_empty & !mem_full.
  - If rd_req & write_ok: go to WR_ISSUE when fifo_count >= WR_THRESHOLD and grant counter < MAX_WR_GRANTS; otherwise go to RD_ISSUE.
  - If only one requester is eligible, serve it.
  - If neither, stay in IDLE.
- Grant counter: increments per write grant while rd_req = 1; clears on a read grant or when rd_req = 0.
- WR_ISSUE (1 cycle): psram_address = wr_ptr, psram_read_write = 1, psram_burst_mode = 1, psram_quad_start = 1. Next state WR_WAIT.
- WR_WAIT:
  - quad_start = 0; read_write and burst_mode held until endcommand.
  - Each fifo_rd pulse advances wr_ptr by 2.
  - At wr_ptr == MEM_TOP, the advance goes to 0 and sets wrapped if WRAP_EN = 1. If WRAP_EN = 0, wr_ptr holds at MEM_TOP and mem_full is set.
  - The driver's first fifo_rd (issue cycle) and its chained pops are all counted, so wr_ptr always equals the next unwritten address.
  - On endcommand: read_write = 0, burst_mode = 0, go to IDLE.
- RD_ISSUE (1 cycle): latch rd_addr into psram_address, psram_read_write = 2, psram_quad_start = 1, burst_mode = 0. Next state RD_WAIT.
- RD_WAIT: on endcommand, capture psram_data_out into rd_data the same cycle. Assert rd_ack the following cycle, clear read_write, return to IDLE. rd_req must drop after rd_ack; a still-high rd_req is treated as a new request.
- Watchdog: counts cycles in WR_WAIT/RD_WAIT. At TIMEOUT without endcommand:
  - set timeout_err, clear read_write/burst_mode, go to IDLE;
  - an aborted read gives no rd_ack and the request is retried.
- endcommand arriving in any state other than WR_WAIT/RD_WAIT is ignored.
- acq_en falling during WR_WAIT does not abort the burst in flight.
- qpi_on falling outside reset: return to INIT after the current command completes.
- rst mid-operation: everything is reinitialised the next cycle, including the sticky flags.

Test Plan:
- Reset, then qpi_on raised at cycle 20 -> state IDLE at cycle 21; all outputs 0; no quad_start before then.
- Write-only: acq_en = 1, FIFO holds 5 words, driver emits 5 fifo_rd then endcommand -> one quad_start with read_write = 1 and burst_mode = 1; wr_ptr 0 → 10; return to IDLE.
- Read-only: rd_req with rd_addr = 23'h001234, driver returns 16'hBEEF -> psram_address 23'h001234, read_write = 2, rd_ack 1 cycle after endcommand, rd_data = 16'hBEEF.
- Contention: rd_req held, fifo_count = 20, MAX_WR_GRANTS = 8 -> exactly 8 write grants, then a read grant; grant counter resets.
- Wrap: wr_ptr preset near MEM_TOP, 3 pops with WRAP_EN = 1 -> sequence MEM_TOP-2 → MEM_TOP → 0, wrapped = 1. With WRAP_EN = 0 -> holds at MEM_TOP, mem_full = 1, no further write grants.
- Watchdog: endcommand withheld after a read issue -> timeout_err = 1 at TIMEOUT cycles, IDLE, read re-issued, rd_ack on the subsequent endcommand.
